// File: rtl/gnt_dispatch.sv
// gnt_dispatch
// ------------
// Takes the registered one-hot grant from the round-robin arbiter. For each
// valid grant it picks the winning client's payload, encodes the client index,
// and pushes {index, payload} into a small output FIFO. The FIFO drains to the
// shared resource over a valid/ready interface.
//
// Ports
//   clk, rst       single clock; asynchronous active-high reset
//   gnt            grant vector from the arbiter (expected one-hot)
//   data_in        flat payloads, client i at [i*DW +: DW]
//   out_vld/rdy    FIFO head handshake
//   out_idx/data   head entry (forced to zero while the FIFO is empty)
//   stall          count >= DEPTH-1, derived from registered count only
//   ovf_err        sticky: a grant was dropped because the FIFO was full
//   onehot_err     sticky: gnt had more than one bit set
//   drop_cnt       saturating count of dropped grants
//   err_clr        synchronous clear of ovf_err, onehot_err and drop_cnt
//
// Handshake: out_vld is high whenever the FIFO holds an entry. A transfer
// (pop) happens on a rising edge where out_vld && out_rdy. While out_rdy is
// low the head entry, out_idx and out_data stay stable. out_vld never depends
// on out_rdy.
module gnt_dispatch #(
  parameter int CLIENTS = 16,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int IDXW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CLIENTS-1:0]    gnt,
  input  logic [CLIENTS*DW-1:0] data_in,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [IDXW-1:0]       out_idx,
  output logic [DW-1:0]         out_data,
  output logic                  stall,
  output logic                  ovf_err,
  output logic                  onehot_err,
  output logic [15:0]           drop_cnt,
  input  logic                  err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IDXW + DW;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  // State
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          onehot_q, onehot_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [EW-1:0] mem_q [DEPTH];

  // Grant decode
  logic            gnt_any;
  logic            multi_hot;
  logic [IDXW-1:0] sel_idx;
  logic [DW-1:0]   sel_data;

  // FIFO control
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] head;

  always_comb begin
    gnt_any   = |gnt;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    multi_hot = |(gnt & (gnt - CLIENTS'(1)));
    sel_idx   = '0;
    // Walking downward makes the last match, the lowest set bit, win.
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (gnt[i]) sel_idx = IDXW'(i);
    end
    sel_data = data_in[sel_idx*DW +: DW];
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    out_vld  = (count_q != '0);
    // Gating with out_vld gives zero head outputs after reset without clearing storage.
    out_idx  = out_vld ? head[EW-1:DW] : '0;
    out_data = out_vld ? head[DW-1:0]  : '0;
    stall    = (count_q >= STALL_CNT);

    pop  = out_vld && out_rdy;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the grant.
    push = gnt_any && ((count_q < FULL_CNT) || pop);
    drop = gnt_any && (count_q == FULL_CNT) && !pop;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    ovf_d      = ovf_q;
    onehot_d   = onehot_q;
    drop_cnt_d = drop_cnt_q;
    if (err_clr) begin
      ovf_d      = 1'b0;
      onehot_d   = 1'b0;
      drop_cnt_d = '0;
    end
    // A new event in the same cycle as err_clr wins over the clear.
    if (drop) begin
      ovf_d = 1'b1;
      if (err_clr)                    drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (multi_hot) onehot_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      onehot_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      onehot_q   <= onehot_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sel_idx, sel_data};
  end

  assign ovf_err    = ovf_q;
  assign onehot_err = onehot_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_gnt_dispatch.sv
// Bench for gnt_dispatch: directed steps from the test plan followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_gnt_dispatch;

  localparam int C     = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int IDXW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [C-1:0]      gnt = '0;
  logic [C*DW-1:0]   data_in = '0;
  logic              out_vld;
  logic              out_rdy = 1'b0;
  logic [IDXW-1:0]   out_idx;
  logic [DW-1:0]     out_data;
  logic              stall;
  logic              ovf_err;
  logic              onehot_err;
  logic [15:0]       drop_cnt;
  logic              err_clr = 1'b0;

  gnt_dispatch #(.CLIENTS(C), .DW(DW), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .gnt(gnt), .data_in(data_in),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx), .out_data(out_data),
    .stall(stall), .ovf_err(ovf_err), .onehot_err(onehot_err),
    .drop_cnt(drop_cnt), .err_clr(err_clr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard and reference model state
  logic [IDXW+DW-1:0] exp_q[$];
  logic               m_ovf = 1'b0;
  logic               m_oh  = 1'b0;
  int                 m_drop = 0;
  int                 pass_cnt = 0;
  int                 total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [IDXW+DW-1:0] hd;
    logic [IDXW-1:0]    e_idx;
    logic [DW-1:0]      e_data;
    hd     = (exp_q.size() > 0) ? exp_q[0] : '0;
    e_idx  = hd[IDXW+DW-1:DW];
    e_data = hd[DW-1:0];
    check({tag, ".vld"},   64'(out_vld),    64'(exp_q.size() > 0));
    check({tag, ".idx"},   64'(out_idx),    64'(e_idx));
    check({tag, ".data"},  64'(out_data),   64'(e_data));
    check({tag, ".stall"}, 64'(stall),      64'(exp_q.size() >= DEPTH - 1));
    check({tag, ".ovf"},   64'(ovf_err),    64'(m_ovf));
    check({tag, ".oh"},    64'(onehot_err), 64'(m_oh));
    check({tag, ".drop"},  64'(drop_cnt),   64'(m_drop));
  endtask

  // Behavioural model of one clock edge, from the current inputs.
  task automatic model_edge();
    bit do_pop, room, found;
    int lo;
    do_pop = (exp_q.size() > 0) && out_rdy;
    room   = (exp_q.size() < DEPTH) || do_pop;
    found  = 0;
    lo     = 0;
    for (int i = 0; i < C; i++) begin
      if (gnt[i] && !found) begin
        lo    = i;
        found = 1;
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (err_clr) begin
      m_ovf  = 1'b0;
      m_oh   = 1'b0;
      m_drop = 0;
    end
    if (found && room) exp_q.push_back({lo[IDXW-1:0], data_in[lo*DW +: DW]});
    if (found && !room) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    if ($countones(gnt) > 1) m_oh = 1'b1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < C; i++) data_in[i*DW +: DW] = $urandom;
  endtask

  // Driver: apply inputs, check current state, then advance one edge.
  task automatic cycle(input string tag, input logic [C-1:0] g, input logic r, input logic c);
    gnt = g; out_rdy = r; err_clr = c;
    #1;
    check_all(tag);
    model_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset phase
    #2;
    check_all("reset");
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Single grant to client 5
    fill_rand();
    data_in[5*DW +: DW] = 32'hA5A5_0005;
    cycle("single_g", 16'h0020, 1'b1, 1'b0);
    fill_rand();
    check("single_idx",  64'(out_idx),  64'd5);
    check("single_data", 64'(out_data), 64'hA5A5_0005);
    cycle("single_pop", '0, 1'b1, 1'b0);
    cycle("single_empty", '0, 1'b1, 1'b0);

    // Fill and drop: five grants with out_rdy low
    for (int k = 0; k < 5; k++) begin
      fill_rand();
      cycle("fill", C'(1) << k, 1'b0, 1'b0);
    end
    check("fill_ovf",  64'(ovf_err),  64'd1);
    check("fill_drop", 64'(drop_cnt), 64'd1);
    check("fill_stall", 64'(stall),   64'd1);
    for (int k = 0; k < 5; k++) cycle("drain", '0, 1'b1, 1'b0);

    // Full push+pop: client 9 arrives while full and out_rdy high
    for (int k = 1; k <= 4; k++) begin
      fill_rand();
      cycle("full_fill", C'(1) << k, 1'b0, 1'b0);
    end
    fill_rand();
    cycle("full_pp", C'(1) << 9, 1'b1, 1'b0);
    check("full_pp_drop", 64'(drop_cnt), 64'd1);
    for (int k = 0; k < 5; k++) cycle("full_drain", '0, 1'b1, 1'b0);

    // Multi-hot grant
    fill_rand();
    cycle("multi", 16'h0C00, 1'b1, 1'b0);
    check("multi_idx", 64'(out_idx),    64'd10);
    check("multi_oh",  64'(onehot_err), 64'd1);
    cycle("multi_pop", '0, 1'b1, 1'b0);
    cycle("multi_clr", '0, 1'b1, 1'b1);
    check("clr_oh", 64'(onehot_err), 64'd0);

    // err_clr coinciding with a drop, after building drop_cnt to 2
    for (int k = 0; k < 6; k++) begin
      fill_rand();
      cycle("pre_drop", C'(1) << k, 1'b0, 1'b0);
    end
    check("pre_drop_cnt", 64'(drop_cnt), 64'd2);
    fill_rand();
    cycle("clr_drop", 16'h0100, 1'b0, 1'b1);
    check("clr_drop_ovf", 64'(ovf_err),  64'd1);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd1);
    for (int k = 0; k < 5; k++) cycle("clr_drain", '0, 1'b1, 1'b0);
    cycle("clr_only", '0, 1'b1, 1'b1);

    // Asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      cycle("pre_rst", C'(1) << (k + 3), 1'b0, 1'b0);
    end
    gnt = '0;
    #3 rst = 1'b1;
    #1;
    exp_q.delete();
    m_ovf = 1'b0; m_oh = 1'b0; m_drop = 0;
    check("rst_vld_now", 64'(out_vld), 64'd0);
    check_all("in_rst");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    fill_rand();
    cycle("post_rst_g", 16'h0080, 1'b1, 1'b0);
    check("post_rst_idx", 64'(out_idx), 64'd7);
    cycle("post_rst_pop", '0, 1'b1, 1'b0);

    // Back-to-back round robin 15..0, 15
    for (int k = 0; k < 17; k++) begin
      fill_rand();
      cycle("rr", C'(1) << (15 - (k % 16)), 1'b1, 1'b0);
    end
    check("rr_drop", 64'(drop_cnt), 64'd0);
    cycle("rr_tail", '0, 1'b1, 1'b0);

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      logic [C-1:0] g;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3)      g = '0;
      else if (sel < 8) g = C'(1) << $urandom_range(0, C - 1);
      else              g = C'($urandom);
      fill_rand();
      cycle("rand", g, ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gnt_dispatch.md
Name: gnt_dispatch

Overview:
- Sits directly downstream of the find-first-set round-robin arbiter and consumes its registered one-hot grant vector.
- On each valid grant it muxes the winning client's payload, encodes the client index, and pushes {index, payload} into a small output FIFO.
- The FIFO drains over a valid/ready interface to the shared resource.
- Provides a stall hint for upstream request gating, plus sticky error and drop accounting for grants that could not be honoured.

Parameters:
- CLIENTS, 16, number of requesters; width of gnt; must match the arbiter.
- DW, 32, payload width per client.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- IDXW, 4, client index width; must equal clog2(CLIENTS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- gnt  input  CLIENTS  one-hot grant from the arbiter, registered at source.
- data_in  input  CLIENTS*DW  flat-packed payloads; client i occupies bits [i*DW +: DW].
- out_vld  output  1  FIFO head valid.
- out_rdy  input  1  consumer ready; a pop occurs when out_vld && out_rdy.
- out_idx  output  IDXW  client index of the head entry.
- out_data  output  DW  payload of the head entry.
- stall  output  1  high when count >= DEPTH-1; upstream uses it to hold off requests.
- ovf_err  output  1  sticky: a grant was dropped because the FIFO was full.
- onehot_err  output  1  sticky: gnt had more than one bit set.
- drop_cnt  output  16  saturating count of dropped grants.
- err_clr  input  1  synchronous clear of ovf_err, onehot_err and drop_cnt.

Behaviour:
- Reset (async assert, clk-synchronous release): rd/wr pointers and count = 0; out_vld = 0; out_idx = 0; out_data = 0; stall = 0; ovf_err = 0; onehot_err = 0; drop_cnt = 0.
  - Reset mid-transfer discards all entries immediately; out_vld drops without waiting for a clock edge.
- Grant decode (combinational):
  - gnt_any = |gnt.
  - idx = position of the lowest set bit of gnt.
  - Selected payload = data_in slice at idx.
- Push occurs when gnt_any && (count < DEPTH || pop). Written entry = {idx, selected payload}.
- Latency: gnt valid in cycle t -> entry written at the edge ending t -> out_vld/out_idx/out_data visible in cycle t+1 if the FIFO was empty.
  - data_in is sampled in the same cycle as gnt; no later re-sampling.
- FIFO ordering and storage:
  - Strict FIFO order.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
  - out_idx/out_data read the head entry combinationally from the storage array.
- Simultaneous push and pop:
  - Full: accepted; count unchanged; no drop.
  - Empty: no pop is possible (out_vld = 0); push only.
- Drop: gnt_any && count == DEPTH && !pop.
  - Entry discarded.
  - ovf_err set next cycle.
  - drop_cnt increments, saturating at 16'hFFFF.
- Multi-hot gnt (popcount > 1):
  - Lowest index is still dispatched, subject to the normal push/drop rules.
  - onehot_err set next cycle.
- gnt == 0: no push, no error.
- out_vld is held and out_idx/out_data are stable while out_rdy is low. Required property: no change to the head entry without a pop.
- stall is registered-state derived only (from count); no combinational path from gnt or out_rdy.
- err_clr clears the sticky flags and drop_cnt. If a new error event coincides with err_clr, the event wins: flag = 1, drop_cnt = 1.

Test Plan:
- Single grant: gnt = 16'h0020, data_in slice 5 = 32'hA5A5_0005, out_rdy = 1 -> next cycle out_vld = 1, out_idx = 5, out_data = 32'hA5A5_0005; FIFO empty afterwards.
- Fill and drop: out_rdy = 0; five consecutive grants to clients 0, 1, 2, 3, 4.
  - stall rises once count reaches 3.
  - Fifth grant dropped: ovf_err = 1, drop_cnt = 1.
  - Raising out_rdy drains idx 0, 1, 2, 3 in order.
- Full push+pop: FIFO full, out_rdy = 1, gnt = client 9 -> count stays 4; no drop; idx 9 emerges as the fourth pop.
- Multi-hot: gnt = 16'h0C00 -> out_idx = 10 dispatched; onehot_err = 1.
  - err_clr pulse clears it.
  - err_clr coinciding with a new drop leaves ovf_err = 1, drop_cnt = 1.
- Async reset mid-stream: assert rst between clock edges with 3 entries queued -> out_vld = 0 immediately; all outputs at reset values; after release the first new grant appears with 1-cycle latency.
- Back-to-back round-robin from the arbiter: all 16 clients requesting, out_rdy = 1 -> out_idx sequence 15, 14, ..., 0, 15 (wraps at the top); one entry per cycle; zero drops.
